light_cycle_engine: RTL and testbench
=====================================

// Module: light_cycle_engine
// PURPOSE
//   Parametrised trail-drawing engine for one light cycle. It keeps a BLKxBLK
//   square's position and heading and redraws the square every STEP_CYCLES.
//   After each redraw it moves the square 1 pixel, leaving a trail.
//   Adds reversal rejection, wall crash detection and an optional wrap mode.
//   Sits between the keyboard direction decoder and the vga_adapter plot port.
// PARAMETERS
//   X_W          8        x coordinate width
//   Y_W          7        y coordinate width
//   X_MAX        159      last visible column
//   Y_MAX        119      last visible row
//   BLK_LOG2     2        square side BLK = 2**BLK_LOG2 pixels
//   STEP_CYCLES  3333336  clk cycles from one STEP to the next (>= BLK*BLK+2)
//   START_X      0        x of square's top-left after reset/restart
//   START_Y      60       y of square's top-left after reset/restart
//   START_DIR    1        heading after reset/restart (00 up, 01 right, 10 down, 11 left)
//   WRAP         0        1: wrap at screen edges; 0: hitting an edge = crash
// PORTS
//   clk        in   1      system clock
//   resetn     in   1      asynchronous active-low reset
//   go         in   1      start (in IDLE) / restart (in DEAD); level, 1-cycle OK
//   dir_valid  in   1      dir_req qualifier
//   dir_req    in   2      requested heading, same encoding as START_DIR
//   colour_in  in   3      trail colour
//   x          out  X_W    pixel x to plot
//   y          out  Y_W    pixel y to plot
//   colour     out  3      pixel colour
//   plot       out  1      write enable to VGA adapter
//   busy       out  1      high in DRAW, WAIT, STEP
//   crashed    out  1      high in DEAD
// BEHAVIOUR
//   - Reset (async): state=IDLE, pos=(START_X,START_Y), heading=pending=START_DIR.
//     Also x=START_X, y=START_Y, colour=0, plot=busy=crashed=0, counters=0.
//   - FSM: IDLE -go-> DRAW. DRAW lasts exactly BLK*BLK cycles, then WAIT.
//     WAIT -(step ctr == STEP_CYCLES-BLK*BLK-2)-> STEP. STEP (1 cycle) -> DRAW, or -> DEAD on crash.
//     DEAD -go-> reload start pos/heading, clear crashed, -> DRAW.
//   - STEP-to-STEP period is exactly STEP_CYCLES clocks.
//   - DRAW: colour_in is sampled on the IDLE/STEP/DEAD->DRAW transition and held.
//     Per cycle k=0..BLK*BLK-1, plot=1, x=pos_x+k[BLK_LOG2-1:0], y=pos_y+k[2*BLK_LOG2-1:BLK_LOG2].
//     This is raster order, x fastest. All of x/y/colour/plot are registered, aligned.
//   - plot=0 outside DRAW; x/y hold their last values.
//   - Direction: a dir_valid cycle with dir_req != (heading ^ 2'b10) loads pending.
//     Reversals are ignored. The last legal request before STEP wins.
//     A request in the STEP cycle counts for the next step.
//     Requests are ignored in IDLE and DEAD.
//   - STEP: heading<=pending; pos moves 1 pixel along the new heading.
//     Up decrements y, down increments y; right increments x, left decrements x.
//     Legal pos range: x 0..X_MAX-BLK+1, y 0..Y_MAX-BLK+1.
//     WRAP=1: leaving one side enters at the opposite limit (0 <-> max), no crash.
//     WRAP=0: a move out of range leaves pos unchanged; state->DEAD, crashed=1.
//   - go while busy is ignored.
//   - resetn low mid-DRAW aborts at once: plot drops asynchronously, no partial state kept.
//   - Position arithmetic uses X_W+1/Y_W+1 bits so underflow is detected, not wrapped silently.
// TESTING
//   1 reset, go=1 for 1 cycle -> 16 plot cycles: (0,60),(1,60)..(3,63), colour=colour_in; then plot=0.
//   2 STEP_CYCLES=40, no input -> the first plot pixels of consecutive draws are exactly 40 cycles apart.
//      x advances 0,1,2...
//   3 heading right, dir_req=11 (left) -> ignored.
//      Then dir_req=00 then 10 in one window -> next step moves down (y 60->61).
//   4 WRAP=0, START_X=156, heading right -> after 1 step crashed=1, plot stays 0.
//      go -> restart at (156,60), crashed=0.
//   5 WRAP=1, START_X=156, heading right -> next draw at x=0..3, crashed stays 0.
//   6 resetn=0 in the 7th DRAW cycle -> plot=0 at once, outputs at reset values; resume needs go.

Source files
------------

// File: rtl/light_cycle_engine.sv
// Light-cycle trail engine: redraws a BLKxBLK square every STEP_CYCLES clocks,
// then moves it one pixel along its heading, with reversal rejection and wall crash/wrap.
module light_cycle_engine #(
  parameter int         X_W         = 8,
  parameter int         Y_W         = 7,
  parameter int         X_MAX       = 159,
  parameter int         Y_MAX       = 119,
  parameter int         BLK_LOG2    = 2,
  parameter int         STEP_CYCLES = 3333336,
  parameter int         START_X     = 0,
  parameter int         START_Y     = 60,
  parameter logic [1:0] START_DIR   = 2'b01,
  parameter bit         WRAP        = 1'b0
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           go,
  input  logic           dir_valid,
  input  logic [1:0]     dir_req,
  input  logic [2:0]     colour_in,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           busy,
  output logic           crashed,
  output logic [2:0]     dbg_state
);

  localparam int BLK       = 1 << BLK_LOG2;
  localparam int NPIX      = BLK * BLK;
  localparam int PIX_W     = 2 * BLK_LOG2;
  localparam int WAIT_LAST = STEP_CYCLES - NPIX - 2;
  localparam int WC_W      = $clog2(STEP_CYCLES);

  localparam logic [X_W:0]     X_LIM    = (X_W+1)'(X_MAX - BLK + 1);
  localparam logic [Y_W:0]     Y_LIM    = (Y_W+1)'(Y_MAX - BLK + 1);
  localparam logic [X_W:0]     X_ONE    = (X_W+1)'(1);
  localparam logic [Y_W:0]     Y_ONE    = (Y_W+1)'(1);
  localparam logic [X_W-1:0]   X0       = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y0       = Y_W'(START_Y);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DRAW = 3'd1,
    S_WAIT = 3'd2,
    S_STEP = 3'd3,
    S_DEAD = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [X_W-1:0]   r_pos_x, r_x, w_step_x, w_base_x;
  logic [Y_W-1:0]   r_pos_y, r_y, w_step_y, w_base_y;
  logic [1:0]       r_heading, r_pending;
  logic [PIX_W-1:0] r_pix, w_pix_n;
  logic [WC_W-1:0]  r_wait;
  logic [2:0]       r_colour;
  logic             r_plot;
  logic [X_W:0]     w_nx;
  logic [Y_W:0]     w_ny;
  logic             w_out_x, w_out_y, w_crash, w_dir_ok, w_enter_draw;

  assign x         = r_x;
  assign y         = r_y;
  assign colour    = r_colour;
  assign plot      = r_plot;
  assign busy      = (r_state == S_DRAW) || (r_state == S_WAIT) || (r_state == S_STEP);
  assign crashed   = (r_state == S_DEAD);
  assign dbg_state = r_state;
  assign w_pix_n   = r_pix + PIX_W'(1);
  assign w_dir_ok  = busy && dir_valid && (dir_req != (r_heading ^ 2'b10));

  // One extra bit on each axis so a step below zero shows up as out of range.
  always_comb begin
    w_nx = {1'b0, r_pos_x};
    w_ny = {1'b0, r_pos_y};
    case (r_pending)
      2'b00:   w_ny = {1'b0, r_pos_y} - Y_ONE;
      2'b01:   w_nx = {1'b0, r_pos_x} + X_ONE;
      2'b10:   w_ny = {1'b0, r_pos_y} + Y_ONE;
      default: w_nx = {1'b0, r_pos_x} - X_ONE;
    endcase
    w_out_x  = (w_nx > X_LIM);
    w_out_y  = (w_ny > Y_LIM);
    w_crash  = !WRAP && (w_out_x || w_out_y);
    w_step_x = w_out_x ? ((r_pending == 2'b11) ? X_LIM[X_W-1:0] : '0) : w_nx[X_W-1:0];
    w_step_y = w_out_y ? ((r_pending == 2'b00) ? Y_LIM[Y_W-1:0] : '0) : w_ny[Y_W-1:0];
  end

  // Top-left of the square about to be drawn, before the position register catches up.
  always_comb begin
    w_base_x = r_pos_x;
    w_base_y = r_pos_y;
    if (r_state == S_STEP) begin
      w_base_x = w_step_x;
      w_base_y = w_step_y;
    end else if (r_state == S_DEAD) begin
      w_base_x = X0;
      w_base_y = Y0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_next = S_DRAW;
      S_DRAW:  if (r_pix == PIX_LAST) w_next = S_WAIT;
      S_WAIT:  if (r_wait == WC_W'(WAIT_LAST)) w_next = S_STEP;
      S_STEP:  w_next = w_crash ? S_DEAD : S_DRAW;
      S_DEAD:  if (go) w_next = S_DRAW;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_draw = (w_next == S_DRAW) && (r_state != S_DRAW);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pos_x   <= X0;
      r_pos_y   <= Y0;
      r_heading <= START_DIR;
      r_pending <= START_DIR;
      r_pix     <= '0;
      r_wait    <= '0;
      r_x       <= X0;
      r_y       <= Y0;
      r_colour  <= 3'd0;
      r_plot    <= 1'b0;
    end else begin
      if (w_dir_ok) r_pending <= dir_req;
      if (r_state == S_STEP) begin
        r_heading <= r_pending;
        if (!w_crash) begin
          r_pos_x <= w_step_x;
          r_pos_y <= w_step_y;
        end
      end
      if (r_state == S_DEAD && go) begin
        r_pos_x   <= X0;
        r_pos_y   <= Y0;
        r_heading <= START_DIR;
        r_pending <= START_DIR;
      end
      r_wait <= (r_state == S_WAIT) ? r_wait + WC_W'(1) : '0;
      // Raster order inside the square: low index bits are the column.
      if (w_enter_draw) begin
        r_plot   <= 1'b1;
        r_pix    <= '0;
        r_colour <= colour_in;
        r_x      <= w_base_x;
        r_y      <= w_base_y;
      end else if (r_state == S_DRAW) begin
        if (r_pix == PIX_LAST) begin
          r_plot <= 1'b0;
        end else begin
          r_pix <= w_pix_n;
          r_x   <= r_pos_x + X_W'(w_pix_n[BLK_LOG2-1:0]);
          r_y   <= r_pos_y + Y_W'(w_pix_n[PIX_W-1:BLK_LOG2]);
        end
      end
    end
  end

endmodule

// File: tb/tb_light_cycle_engine.sv
// Bench for light_cycle_engine: pixel scoreboard on a fast-step instance plus
// crash and wrap instances started at the right wall.
module tb_light_cycle_engine;

  localparam int W = 18;

  logic       clk = 1'b0;
  logic       resetn;
  logic       go_a, go_b, go_c, dir_valid;
  logic [1:0] dir_req;
  logic [2:0] colour_in;

  logic [7:0] a_x, b_x, c_x;
  logic [6:0] a_y, b_y, c_y;
  logic [2:0] a_colour, b_colour, c_colour, a_state, b_state, c_state;
  logic       a_plot, b_plot, c_plot, a_busy, b_busy, c_busy;
  logic       a_crashed, b_crashed, c_crashed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  light_cycle_engine #(.STEP_CYCLES(40)) dut_a (
    .clk(clk), .resetn(resetn), .go(go_a), .dir_valid(dir_valid), .dir_req(dir_req),
    .colour_in(colour_in), .x(a_x), .y(a_y), .colour(a_colour), .plot(a_plot),
    .busy(a_busy), .crashed(a_crashed), .dbg_state(a_state));

  light_cycle_engine #(.STEP_CYCLES(40), .START_X(156), .WRAP(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .go(go_b), .dir_valid(1'b0), .dir_req(2'b00),
    .colour_in(colour_in), .x(b_x), .y(b_y), .colour(b_colour), .plot(b_plot),
    .busy(b_busy), .crashed(b_crashed), .dbg_state(b_state));

  light_cycle_engine #(.STEP_CYCLES(40), .START_X(156), .WRAP(1'b1)) dut_c (
    .clk(clk), .resetn(resetn), .go(go_c), .dir_valid(1'b0), .dir_req(2'b00),
    .colour_in(colour_in), .x(c_x), .y(c_y), .colour(c_colour), .plot(c_plot),
    .busy(c_busy), .crashed(c_crashed), .dbg_state(c_state));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_square(input int x0, input int y0, input int c, input int n);
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    for (int k = 0; k < n; k++) begin
      px = 8'(x0 + (k % 4));
      py = 7'(y0 + (k / 4));
      pc = 3'(c);
      exp_q.push_back({px, py, pc});
    end
  endtask

  // Every plotted pixel of dut_a must match the next expected one.
  always @(negedge clk) begin
    if (a_plot) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_plot", {a_x, a_y, a_colour}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("pixel", {a_x, a_y, a_colour}, mon_e);
      end
    end
  end

  function automatic logic plot_of(input int sel);
    case (sel)
      0:       return a_plot;
      1:       return b_plot;
      default: return c_plot;
    endcase
  endfunction

  task automatic wait_rise(input int sel, input int budget, output int at);
    logic prev, p;
    at = -1;
    prev = plot_of(sel);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      p = plot_of(sel);
      if (p && !prev) begin
        at = cyc;
        break;
      end
      prev = p;
    end
    if (at < 0) check_eq("rise_timeout", 32'(sel), 32'hFFFF_FFFF);
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5, n_plot;
    go_a = 0; go_b = 0; go_c = 0;
    dir_valid = 0; dir_req = 2'b00; colour_in = 3'd5;
    resetn = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_plot",   a_plot, 0);
    check_eq("rst_x",      a_x, 0);
    check_eq("rst_y",      a_y, 60);
    check_eq("rst_colour", a_colour, 0);
    check_eq("rst_busy",   a_busy, 0);
    check_eq("rst_crash",  a_crashed, 0);
    check_eq("rst_state",  a_state, 0);
    check_eq("rst_b_x",    b_x, 156);
    resetn = 1;

    // Crash at the right wall, then restart.
    @(negedge clk) go_b = 1;
    @(negedge clk) go_b = 0;
    check_eq("b_first_plot", b_plot, 1);
    check_eq("b_first_x",    b_x, 156);
    check_eq("b_busy",       b_busy, 1);
    repeat (20) @(negedge clk);
    n_plot = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_plot) n_plot++;
    end
    check_eq("b_crashed",      b_crashed, 1);
    check_eq("b_no_plot_dead", n_plot, 0);
    check_eq("b_idle_busy",    b_busy, 0);
    check_eq("b_hold_x",       b_x, 159);
    check_eq("b_hold_y",       b_y, 63);
    @(negedge clk) go_b = 1;
    @(negedge clk) go_b = 0;
    check_eq("b_restart_plot",  b_plot, 1);
    check_eq("b_restart_x",     b_x, 156);
    check_eq("b_restart_y",     b_y, 60);
    check_eq("b_restart_crash", b_crashed, 0);

    // Wrap from the right wall to column 0.
    @(negedge clk) go_c = 1;
    @(negedge clk) go_c = 0;
    check_eq("c_first_x", c_x, 156);
    wait_rise(2, 60, t0);
    check_eq("c_wrap_x",     c_x, 0);
    check_eq("c_wrap_y",     c_y, 60);
    check_eq("c_wrap_crash", c_crashed, 0);
    @(negedge clk);
    check_eq("c_wrap_x1", c_x, 1);

    // Trail, period, colour sampling and direction handling.
    push_square(0, 60, 5, 16);
    push_square(1, 60, 3, 16);
    push_square(2, 60, 3, 16);
    push_square(3, 60, 3, 16);
    push_square(3, 61, 3, 16);
    push_square(3, 62, 3, 7);
    @(negedge clk) go_a = 1;
    @(negedge clk) go_a = 0;
    t0 = cyc;
    repeat (4) @(negedge clk);
    colour_in = 3'd3;
    wait_rise(0, 60, t1);
    check_eq("period_1", t1 - t0, 40);
    wait_rise(0, 60, t2);
    check_eq("period_2", t2 - t1, 40);
    check_eq("x_advance", a_x, 2);
    repeat (20) @(negedge clk);
    dir_valid = 1; dir_req = 2'b11;
    @(negedge clk) dir_valid = 0;
    wait_rise(0, 60, t3);
    check_eq("reverse_ignored_y", a_y, 60);
    check_eq("reverse_ignored_x", a_x, 3);
    repeat (20) @(negedge clk);
    dir_valid = 1; dir_req = 2'b00;
    @(negedge clk) dir_req = 2'b10;
    @(negedge clk) dir_valid = 0;
    wait_rise(0, 60, t4);
    check_eq("turn_down_y", a_y, 61);
    check_eq("turn_down_x", a_x, 3);

    // Reset in the 7th DRAW cycle.
    wait_rise(0, 60, t5);
    repeat (6) @(negedge clk);
    #2 resetn = 0;
    #1;
    check_eq("abort_plot",   a_plot, 0);
    check_eq("abort_x",      a_x, 0);
    check_eq("abort_y",      a_y, 60);
    check_eq("abort_colour", a_colour, 0);
    check_eq("abort_state",  a_state, 0);
    check_eq("abort_queue",  exp_q.size(), 0);
    @(negedge clk) resetn = 1;
    repeat (60) @(negedge clk);
    check_eq("idle_after_rst", a_state, 0);
    colour_in = 3'd6;
    push_square(0, 60, 6, 16);
    @(negedge clk) go_a = 1;
    @(negedge clk) go_a = 0;
    repeat (20) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
